// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default widths for the sequence pattern blocks
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/seq_down_cnt.sv
// seq_down_cnt: loadable down-counter with zero flag; saturates at zero, load beats decrement
//   clk, rst : clock, async active-high reset
//   load_i   : load val_i into the counter
//   dec_i    : decrement by one when nonzero
//   zero_o   : counter is zero
module seq_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, MSB-first, with repeat count and idle gap
//   load_valid/load_ready : load handshake for pattern, pat_len, repeats, gap_len
//   abort                 : drop the current job and return to idle
//   data/data_valid       : registered serial stream, idle level 0
//   busy/done             : job in progress / one-cycle completion pulse
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] repeats,
  input  logic [CNT_W-1:0] gap_len,
  input  logic             abort,
  output logic             data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);
  state_t           state_q;
  logic [PAT_W-1:0] pat_q, sh_q, aligned;
  logic [LEN_W-1:0] lm1_q, eff_len, bit_val;
  logic [CNT_W-1:0] gap_q;
  logic load, end_pat, bit_ld, bit_dec, gap_ld;
  logic bit_zero, rep_zero, gap_zero;
  // pattern is left-aligned so the first bit always sits at the MSB of the shift register
  always_comb begin
    load    = state_q == IDLE && load_valid;
    eff_len = (pat_len == '0 || pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;
    aligned = pattern << (LEN_W'(PAT_W) - eff_len);
    end_pat = state_q == SEND && bit_zero;
    bit_ld  = load || (end_pat && !rep_zero && gap_q == '0) || (state_q == GAP && gap_zero);
    bit_val = load ? eff_len - LEN_W'(1) : lm1_q;
    bit_dec = state_q == SEND && !bit_zero;
    gap_ld  = end_pat && gap_q != '0;
  end
  // bit index of the bit on data; remaining repeats after the current one; gap cycles left
  seq_down_cnt #(.W(LEN_W)) u_bit (.clk(clk), .rst(rst), .load_i(bit_ld), .val_i(bit_val),
    .dec_i(bit_dec), .zero_o(bit_zero));
  seq_down_cnt #(.W(CNT_W)) u_rep (.clk(clk), .rst(rst), .load_i(load), .val_i(repeats - CNT_W'(1)),
    .dec_i(end_pat), .zero_o(rep_zero));
  seq_down_cnt #(.W(CNT_W)) u_gap (.clk(clk), .rst(rst), .load_i(gap_ld), .val_i(gap_q - CNT_W'(1)),
    .dec_i(state_q == GAP), .zero_o(gap_zero));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      sh_q       <= '0;
      lm1_q      <= '0;
      gap_q      <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state_q != IDLE && abort) begin
        state_q    <= IDLE;
        data       <= 1'b0;
        data_valid <= 1'b0;
        busy       <= 1'b0;
        load_ready <= 1'b1;
      end else
        case (state_q)
          IDLE: if (load_valid) begin
            pat_q      <= aligned;
            sh_q       <= aligned << 1;
            lm1_q      <= eff_len - LEN_W'(1);
            gap_q      <= gap_len;
            busy       <= 1'b1;
            load_ready <= 1'b0;
            if (repeats == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else begin
              state_q    <= SEND;
              data       <= aligned[PAT_W-1];
              data_valid <= 1'b1;
            end
          end
          SEND: if (!bit_zero) begin
            data <= sh_q[PAT_W-1];
            sh_q <= sh_q << 1;
          end else if (rep_zero) begin
            state_q    <= DONE;
            data       <= 1'b0;
            data_valid <= 1'b0;
            done       <= 1'b1;
          end else if (gap_q == '0) begin
            data <= pat_q[PAT_W-1];
            sh_q <= pat_q << 1;
          end else begin
            state_q    <= GAP;
            data       <= 1'b0;
            data_valid <= 1'b0;
          end
          GAP: if (gap_zero) begin
            state_q    <= SEND;
            data       <= pat_q[PAT_W-1];
            data_valid <= 1'b1;
            sh_q       <= pat_q << 1;
          end
          default: begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end
        endcase
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: table-driven check of seq_pattern_tx plus abort and reset sequences
module tb_seq_pattern_tx;
  logic clk, rst, load_valid, load_ready, abort, data, data_valid, busy, done;
  logic [7:0] pattern, repeats, gap_len;
  logic [3:0] pat_len;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [7:0]  rep;
    logic [7:0]  gap;
    logic        ab;
    int          n;
    logic [31:0] d;
    logic [31:0] v;
    logic [31:0] dn;
    logic [31:0] b;
  } vec_t;
  vec_t vecs[8];
  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .pat_len(pat_len), .repeats(repeats), .gap_len(gap_len),
    .abort(abort), .data(data), .data_valid(data_valid), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string tag, input logic d, input logic v, input logic dn, input logic b);
    chk({tag, " data"}, data, d);
    chk({tag, " data_valid"}, data_valid, v);
    chk({tag, " done"}, done, dn);
    chk({tag, " busy"}, busy, b);
    chk({tag, " load_ready"}, load_ready, ~b);
  endtask
  task automatic drive_load(input vec_t v);
    pattern    = v.pat;
    pat_len    = v.len;
    repeats    = v.rep;
    gap_len    = v.gap;
    abort      = v.ab;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    abort      = 1'b0;
    pattern    = ~v.pat;
    pat_len    = 4'd1;
    repeats    = 8'd0;
    gap_len    = 8'd7;
  endtask
  task automatic run_vec(input vec_t v, input int id);
    chk($sformatf("v%0d ready_before_load", id), load_ready, 1'b1);
    drive_load(v);
    for (int c = 0; c < v.n; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      chk_out($sformatf("v%0d c%0d", id, c), v.d[c], v.v[c], v.dn[c], v.b[c]);
    end
  endtask
  initial begin
    vecs[0] = '{8'h09, 4'd4,  8'd2, 8'd2, 1'b0, 12, 32'h249, 32'h3CF, 32'h400,  32'h7FF};
    vecs[1] = '{8'h09, 4'd4,  8'd3, 8'd0, 1'b0, 14, 32'h999, 32'hFFF, 32'h1000, 32'h1FFF};
    vecs[2] = '{8'h09, 4'd4,  8'd0, 8'd2, 1'b0, 3,  32'h0,   32'h0,   32'h1,    32'h1};
    vecs[3] = '{8'hA5, 4'd0,  8'd1, 8'd0, 1'b0, 10, 32'hA5,  32'hFF,  32'h100,  32'h1FF};
    vecs[4] = '{8'hA5, 4'd8,  8'd1, 8'd0, 1'b0, 10, 32'hA5,  32'hFF,  32'h100,  32'h1FF};
    vecs[5] = '{8'hFD, 4'd3,  8'd1, 8'd0, 1'b1, 5,  32'h5,   32'h7,   32'h8,    32'hF};
    vecs[6] = '{8'h81, 4'd12, 8'd1, 8'd0, 1'b0, 10, 32'h81,  32'hFF,  32'h100,  32'h1FF};
    vecs[7] = '{8'h02, 4'd2,  8'd2, 8'd1, 1'b0, 7,  32'h9,   32'h1B,  32'h20,   32'h3F};
    rst = 1'b1; load_valid = 1'b0; abort = 1'b0;
    pattern = '0; pat_len = '0; repeats = '0; gap_len = '0;
    #2;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_out("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    // abort in the second gap cycle, then an immediate reload
    drive_load(vecs[0]);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    chk_out("abort gap2", 1'b0, 1'b0, 1'b0, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk_out("abort idle", 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec(vecs[1], 8);
    // asynchronous reset in the middle of SEND
    drive_load(vecs[3]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_out("pre_rst c2", 1'b1, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 chk_out("rst_mid_send", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_out($sformatf("post_rst c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_vec(vecs[7], 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter, the counterpart of the team's serial sequence detector. It accepts a parallel bit pattern through a valid/ready load handshake and shifts it out MSB-first, one bit per clock, on a single-bit `data` line. It can repeat the pattern N times with a programmable idle gap between repetitions. It drives detector benches and on-chip self-test of the detector path. Detector-compatible stream: idle level 0, one bit per `clk`.

## Interface
Parameters:
- PAT_W, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, width of the repeat and gap count fields
- LEN_W, $clog2(PAT_W+1), width of the pattern-length field

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- load_valid  in  1  load request
- load_ready  out  1  block can accept a load
- pattern  in  PAT_W  pattern bits; the transmitted bits are pattern[pat_len-1:0], MSB-first
- pat_len  in  LEN_W  number of pattern bits; 0 or >PAT_W is treated as PAT_W
- repeats  in  CNT_W  number of pattern transmissions; 0 means none
- gap_len  in  CNT_W  idle cycles between consecutive transmissions
- abort  in  1  synchronous abort of the current job
- data  out  1  serial output, registered
- data_valid  out  1  high while `data` carries a pattern bit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job completes normally

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1: capture pattern, the effective length L, repeats R and gap G.
  - If R=0, go to DONE.
  - Otherwise go to SEND and, on that same edge, set data=pattern[L-1] and data_valid=1.
- SEND: each edge presents the next lower bit. After bit 0 has been presented for one cycle, the remaining-repeat count is decremented:
  - Remaining = 0 → DONE.
  - Remaining > 0 and G > 0 → GAP for exactly G cycles, with data=0 and data_valid=0.
  - Remaining > 0 and G = 0 → the next transmission starts back-to-back: its first bit follows the previous bit 0 with no idle cycle.
- GAP: when the gap count expires, go to SEND and present pattern[L-1] on that edge.
- DONE: lasts one cycle with done=1, data=0, load_ready=0. Then return to IDLE.
- abort=1 in SEND, GAP or DONE: go to IDLE on the next edge, with data=0, data_valid=0 and no done pulse. abort is ignored in IDLE. If load_valid and abort are both high in IDLE, the load wins.
- Captured fields are held for the whole job; input changes during busy have no effect.
- Effective length and repeat arithmetic is unsigned. Counters never wrap; R=2^CNT_W−1 is a legal maximum.

## Timing
- Reset values: load_ready=1, data=0, data_valid=0, busy=0, done=0, state=IDLE.
- Asynchronous reset mid-job clears all state immediately; the job is discarded.
- Load-to-first-bit latency: the first bit is valid in the cycle right after the accepting edge.
- Job length for R≥1: R·L + (R−1)·G cycles of SEND/GAP, then 1 DONE cycle. load_ready returns high the cycle after DONE.
- Back-to-back jobs: a new load can be accepted at the edge where IDLE is re-entered plus one. There is a minimum one-cycle IDLE between jobs.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `seq_pkg` holds the state encoding localparams (IDLE/SEND/GAP/DONE) and the default PAT_W and CNT_W. The detector-side block and its benches share this package.
- One natural sub-module, `seq_down_cnt`: a loadable down-counter with a zero flag. It is instantiated three times, for the bit index, the remaining repeats and the gap count.
- The top module holds the FSM, the capture registers and the output registers.

## Test plan
- Load pattern=4'b1001, L=4, R=2, G=2 → data = 1,0,0,1,0,0,1,0,0,1 on the cycles after accept. data_valid is high only on the eight pattern bits. done pulses the cycle after the last bit; then data=0.
- Load pattern=4'b1001, L=4, R=3, G=0 → 12 contiguous valid bits 100110011001. busy is high for 13 cycles. Exactly one done pulse.
- Load with R=0 → no valid bits. done pulses the cycle after accept. load_ready is low for exactly one cycle.
- Load pat_len=0 with pattern=8'hA5 → 8 bits 10100101 MSB-first, the same as pat_len=8.
- Abort in the second GAP cycle of the first scenario → IDLE on the next edge, no done pulse. A new load one cycle later is accepted and transmits correctly.
- Assert rst mid-SEND → all outputs go to reset values immediately. After release, the block sits in IDLE with load_ready=1.
